// File: rtl/matrix4_pkg.sv
// Shared types and sizes for the 4x4 matrix multiplier.
package matrix4_pkg;
  localparam int DIM    = 4;
  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] elem_t;
  typedef elem_t mat_t [0:DIM-1][0:DIM-1];

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
endpackage

// File: rtl/matrix4_multiply_dot4.sv
// Combinational 4-term dot product; every partial result wraps mod 2^DATA_W,
// which gives the same low bits as a full-width sum truncated at the end.
module dot4
  import matrix4_pkg::*;
(
  input  logic [DATA_W-1:0] i_row [0:DIM-1],
  input  logic [DATA_W-1:0] i_col [0:DIM-1],
  output logic [DATA_W-1:0] o_dot
);

  elem_t w_acc;

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < DIM; k++) begin
      w_acc = w_acc + i_row[k] * i_col[k];
    end
  end

  assign o_dot = w_acc;

endmodule

// File: rtl/matrix4_multiply.sv
// 4x4 unsigned matrix multiplier: latches A/B on accept, produces one element
// of M per clock, then holds M until the consumer takes it.
module matrix4_multiply
  import matrix4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              source_ready,
  input  logic              input_valid,
  input  logic [DATA_W-1:0] A [0:DIM-1][0:DIM-1],
  input  logic [DATA_W-1:0] B [0:DIM-1][0:DIM-1],
  output logic [DATA_W-1:0] M [0:DIM-1][0:DIM-1],
  output logic              sink_ready,
  output logic              output_valid
);

  state_t      r_state;
  logic [3:0]  r_index;
  elem_t       r_aLat [0:DIM-1][0:DIM-1];
  elem_t       r_bLat [0:DIM-1][0:DIM-1];
  logic [1:0]  w_i;
  logic [1:0]  w_j;
  elem_t       w_row [0:DIM-1];
  elem_t       w_col [0:DIM-1];
  elem_t       w_dot;

  assign w_i = r_index[3:2];
  assign w_j = r_index[1:0];

  // Row i of the latched A and column j of the latched B feed the single dot unit.
  always_comb begin
    for (int k = 0; k < DIM; k++) begin
      w_row[k] = r_aLat[w_i][k];
      w_col[k] = r_bLat[k][w_j];
    end
  end

  dot4 u_dot4 (
    .i_row (w_row),
    .i_col (w_col),
    .o_dot (w_dot)
  );

  assign sink_ready   = (r_state == IDLE) && !rst;
  assign output_valid = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_index <= '0;
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          M[i][j] <= '0;
        end
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (input_valid) begin
            r_aLat  <= A;
            r_bLat  <= B;
            r_index <= '0;
            r_state <= COMPUTE;
          end
        end
        COMPUTE: begin
          M[w_i][w_j] <= w_dot;
          r_index     <= r_index + 4'd1;
          // Writing the last element (index 15) completes the job.
          if (r_index == 4'd15) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (source_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix4_multiply.sv
// Directed bench for matrix4_multiply with a queue of expected products
// that is filled on accept and drained when output_valid is seen.
module tb_matrix4_multiply;
  import matrix4_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic source_ready;
  logic input_valid;
  mat_t A;
  mat_t B;
  mat_t M;
  logic sink_ready;
  logic output_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [255:0] sbQueue [$];

  matrix4_multiply dut (
    .clk          (clk),
    .rst          (rst),
    .source_ready (source_ready),
    .input_valid  (input_valid),
    .A            (A),
    .B            (B),
    .M            (M),
    .sink_ready   (sink_ready),
    .output_valid (output_valid)
  );

  always #5 clk = ~clk;

  // Hard stop in case the bench itself gets stuck.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [255:0] packMat(input mat_t m);
    logic [255:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        p[(i*4+j)*16 +: 16] = m[i][j];
    return p;
  endfunction

  function automatic logic [255:0] refProduct(input mat_t a, input mat_t b);
    logic [255:0] p;
    logic [31:0]  s;
    p = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 32'd0;
        for (int k = 0; k < 4; k++)
          s = s + 32'(a[i][k]) * 32'(b[k][j]);
        p[(i*4+j)*16 +: 16] = s[15:0];
      end
    return p;
  endfunction

  function automatic mat_t randMat();
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[i][j] = 16'($urandom);
    return m;
  endfunction

  function automatic mat_t fillMat(input logic [15:0] v);
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[i][j] = v;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkVal(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one job; the accept happens at the next edge.
  task automatic applyStimulus(input string tag, input mat_t a, input mat_t b, input logic [255:0] exp);
    checkVal({tag, "_sink_ready"}, 256'(sink_ready), 256'(1));
    A = a;
    B = b;
    input_valid = 1'b1;
    sbQueue.push_back(exp);
    tick();
    input_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    total++;
    assert (sbQueue.size() != 0) else begin
      bad++;
      $error("[TB] FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (sbQueue.size() != 0)
      checkVal({tag, "_m"}, packMat(M), sbQueue.pop_front());
    checkVal({tag, "_valid"}, 256'(output_valid), 256'(1));
  endtask

  // Wait for output_valid with a cycle budget; optionally churn A/B meanwhile.
  task automatic waitDone(input string tag, input bit scramble);
    int n;
    n = 0;
    while (!output_valid && n < 40) begin
      if (scramble) begin
        A = randMat();
        B = randMat();
        input_valid = 1'b1;
      end
      tick();
      n++;
    end
    checkVal({tag, "_latency"}, 256'(n), 256'(16));
  endtask

  task automatic releaseJob(input string tag);
    source_ready = 1'b1;
    tick();
    source_ready = 1'b0;
    checkVal({tag, "_valid_drop"}, 256'(output_valid), 256'(0));
    checkVal({tag, "_sink_rise"}, 256'(sink_ready), 256'(1));
  endtask

  task automatic runJob(input string tag, input mat_t a, input mat_t b);
    applyStimulus(tag, a, b, refProduct(a, b));
    waitDone(tag, 1'b0);
    checkOutput(tag);
    releaseJob(tag);
  endtask

  initial begin
    mat_t a1, b1, m1, x, y, ident;
    logic [255:0] held;
    int sel, jobs, accepted, acceptEdge, lastDone;

    rst = 1'b1;
    source_ready = 1'b0;
    input_valid = 1'b0;
    A = fillMat(16'd0);
    B = fillMat(16'd0);

    // Reset state
    tick();
    tick();
    checkVal("rst_valid", 256'(output_valid), 256'(0));
    checkVal("rst_sink", 256'(sink_ready), 256'(0));
    checkVal("rst_m", packMat(M), 256'(0));
    rst = 1'b0;
    #1;
    checkVal("rst_sink_after", 256'(sink_ready), 256'(1));
    tick();

    // Basic product with expected result written out by hand
    $display("[TB] basic product");
    a1 = '{'{16'd0, 16'd1, 16'd2, 16'd3}, '{16'd4, 16'd5, 16'd6, 16'd7},
           '{16'd8, 16'd9, 16'd0, 16'd1}, '{16'd2, 16'd3, 16'd4, 16'd5}};
    b1 = '{'{16'd1, 16'd2, 16'd1, 16'd2}, '{16'd2, 16'd4, 16'd2, 16'd4},
           '{16'd1, 16'd2, 16'd1, 16'd2}, '{16'd2, 16'd4, 16'd2, 16'd4}};
    m1 = '{'{16'd10, 16'd20, 16'd10, 16'd20}, '{16'd34, 16'd68, 16'd34, 16'd68},
           '{16'd28, 16'd56, 16'd28, 16'd56}, '{16'd22, 16'd44, 16'd22, 16'd44}};
    applyStimulus("basic", a1, b1, packMat(m1));
    waitDone("basic", 1'b0);
    held = packMat(M);
    checkOutput("basic");
    checkVal("basic_sink_busy", 256'(sink_ready), 256'(0));

    // Backpressure: hold DONE for 20 cycles
    $display("[TB] backpressure");
    for (int t = 0; t < 20; t++) begin
      tick();
      checkVal("bp_valid", 256'(output_valid), 256'(1));
      checkVal("bp_m", packMat(M), held);
      checkVal("bp_sink", 256'(sink_ready), 256'(0));
    end
    releaseJob("bp");

    // Overflow and wraparound
    $display("[TB] overflow");
    runJob("ovf_zero", fillMat(16'h0100), fillMat(16'h0100));
    ident = fillMat(16'd0);
    for (int i = 0; i < 4; i++) ident[i][i] = 16'd1;
    applyStimulus("ovf_ffff", fillMat(16'hFFFF), ident, {16{16'hFFFF}});
    waitDone("ovf_ffff", 1'b0);
    checkOutput("ovf_ffff");
    releaseJob("ovf_ffff");

    // Operand isolation: churn inputs during COMPUTE and DONE
    $display("[TB] isolation");
    x = randMat();
    y = randMat();
    applyStimulus("iso", x, y, refProduct(x, y));
    waitDone("iso", 1'b1);
    checkOutput("iso");
    releaseJob("iso");
    input_valid = 1'b0;
    tick();
    checkVal("iso_no_second", 256'(output_valid | !sink_ready), 256'(0));

    // Reset in the middle of a computation
    $display("[TB] reset mid-op");
    x = randMat();
    y = randMat();
    applyStimulus("midrst", x, y, refProduct(x, y));
    for (int t = 0; t < 7; t++) tick();
    rst = 1'b1;
    tick();
    void'(sbQueue.pop_front());
    checkVal("midrst_valid", 256'(output_valid), 256'(0));
    checkVal("midrst_m", packMat(M), 256'(0));
    checkVal("midrst_sink", 256'(sink_ready), 256'(0));
    rst = 1'b0;
    #1;
    checkVal("midrst_sink_after", 256'(sink_ready), 256'(1));
    tick();
    runJob("post_rst", randMat(), randMat());

    // Back-to-back with source_ready and input_valid held high
    $display("[TB] back-to-back");
    x = randMat();
    y = randMat();
    sel = 0;
    jobs = 0;
    accepted = 0;
    acceptEdge = 0;
    lastDone = -1;
    source_ready = 1'b1;
    for (int t = 0; t < 100 && jobs < 3; t++) begin
      A = (sel == 0) ? x : y;
      B = (sel == 0) ? y : x;
      input_valid = (accepted < 3);
      if (sink_ready && input_valid) begin
        sbQueue.push_back(refProduct(A, B));
        acceptEdge = cyc + 1;
        accepted++;
        sel = 1 - sel;
      end
      tick();
      if (output_valid) begin
        checkVal("b2b_latency", 256'(cyc - acceptEdge), 256'(16));
        if (lastDone >= 0)
          checkVal("b2b_spacing", 256'(cyc - lastDone), 256'(18));
        lastDone = cyc;
        checkOutput("b2b");
        jobs++;
      end
    end
    input_valid = 1'b0;
    source_ready = 1'b0;
    checkVal("b2b_jobs", 256'(jobs), 256'(3));
    checkVal("sb_empty", 256'(sbQueue.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
